// File: rtl/pool_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pool_window_feeder
// Brief    : Buffers one K-row band of a raster feature-map stream and replays
//            each non-overlapping KxK window serially to a pooling unit.
//            Define POOL_FEED_PAD_EN to emit padded partial edge windows.
// Revision : 1.0
// ============================================================================
module pool_window_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 64,
    parameter int MAX_KERNEL = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(MAX_WIDTH):0]    cfg_width,
    input  logic [15:0]                   cfg_height,
    input  logic [1:0]                    kernel_size,
    input  logic [1:0]                    pool_type,
    input  logic                          frame_start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          pool_start,
    output logic                          pool_valid,
    output logic [DATA_WIDTH-1:0]         pool_data,
    input  logic                          pool_busy,
    input  logic                          pool_done,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int CW = $clog2(MAX_WIDTH) + 1;
    localparam int AW = $clog2(MAX_WIDTH);
    localparam int KW = ($clog2(MAX_KERNEL + 1) < 2) ? 2 : $clog2(MAX_KERNEL + 1);
    localparam int RW = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;
    localparam int XW = CW + KW + 2;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FILL  = 3'd1;
    localparam logic [2:0] c_S_START = 3'd2;
    localparam logic [2:0] c_S_EMIT  = 3'd3;
    localparam logic [2:0] c_S_WAIT  = 3'd4;

    localparam logic [CW-1:0] c_W_MAX = CW'(MAX_WIDTH);
    localparam logic [KW-1:0] c_K2    = KW'(2);
    localparam logic [KW-1:0] c_K3    = KW'(3);

    logic [2:0]             r_state;
    logic [CW-1:0]          r_width;
    logic [KW-1:0]          r_k;
    logic [15:0]            r_rows_left;
    logic [CW-1:0]          r_col;
    logic [KW-1:0]          r_band_row;
    logic [CW-1:0]          r_wx;
    logic [KW-1:0]          r_ei;
    logic [KW-1:0]          r_ej;
    logic                   r_pool_start;
    logic                   r_pool_valid;
    logic [DATA_WIDTH-1:0]  r_pool_data;
    logic                   r_frame_done;
`ifdef POOL_FEED_PAD_EN
    logic [1:0]             r_pool_type;
    logic [KW-1:0]          r_valid_rows;
`endif

    logic [DATA_WIDTH-1:0]  r_buf [0:MAX_KERNEL-1][0:MAX_WIDTH-1];

    logic [CW-1:0]          w_cfg_width;
    logic [15:0]            w_cfg_height;
    logic                   w_accept;
    logic                   w_row_end;
    logic                   w_last_row;
    logic                   w_band_last;
    logic [16:0]            w_rows_avail;
    logic                   w_tail;
    logic                   w_band_done;
    logic                   w_store;
    logic [XW-1:0]          w_k_x;
    logic [XW-1:0]          w_w_x;
    logic [XW-1:0]          w_base_col;
    logic [XW-1:0]          w_rd_col;
    logic                   w_first_fits;
    logic                   w_next_fits;
    logic                   w_ej_last;
    logic                   w_ei_last;
    logic [DATA_WIDTH-1:0]  w_rd_sample;
    logic [DATA_WIDTH-1:0]  w_emit_data;
    logic                   w_unused;

    assign w_cfg_width  = (cfg_width > c_W_MAX) ? c_W_MAX :
                          ((cfg_width == '0) ? CW'(1) : cfg_width);
    assign w_cfg_height = (cfg_height == 16'd0) ? 16'd1 : cfg_height;

    assign w_accept    = (r_state == c_S_FILL) && in_valid;
    assign w_row_end   = (r_col == (r_width - CW'(1)));
    assign w_last_row  = (r_rows_left == 16'd1);
    assign w_band_last = (r_band_row == (r_k - KW'(1)));

    // Rows still to arrive, counted from the top of the current band.
    assign w_rows_avail = {1'b0, r_rows_left} + {{(17-KW){1'b0}}, r_band_row};
    assign w_tail       = (w_rows_avail < {{(17-KW){1'b0}}, r_k});

    assign w_k_x      = {{(XW-KW){1'b0}}, r_k};
    assign w_w_x      = {{(XW-CW){1'b0}}, r_width};
    assign w_base_col = {{(XW-CW){1'b0}}, r_wx} * w_k_x;
    assign w_rd_col   = w_base_col + {{(XW-KW){1'b0}}, r_ej};
    assign w_ej_last  = (r_ej == (r_k - KW'(1)));
    assign w_ei_last  = (r_ei == (r_k - KW'(1)));

    assign w_rd_sample = r_buf[r_ei[RW-1:0]][w_rd_col[AW-1:0]];

`ifdef POOL_FEED_PAD_EN
    logic                   w_is_pad;
    logic [DATA_WIDTH-1:0]  w_pad_val;

    // The last frame row closes the band early; missing rows become padding.
    assign w_band_done  = w_band_last || w_last_row;
    assign w_store      = 1'b1;
    assign w_first_fits = 1'b1;
    assign w_next_fits  = ((w_base_col + w_k_x) < w_w_x);
    assign w_pad_val    = (r_pool_type == 2'd0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;
    assign w_is_pad     = (r_ei >= r_valid_rows) || (w_rd_col >= w_w_x);
    assign w_emit_data  = w_is_pad ? w_pad_val : w_rd_sample;
`else
    assign w_band_done  = !w_tail && w_band_last;
    assign w_store      = !w_tail;
    assign w_first_fits = (w_k_x <= w_w_x);
    assign w_next_fits  = ((w_base_col + (w_k_x << 1)) <= w_w_x);
    assign w_emit_data  = w_rd_sample;
`endif

    assign w_unused = ^{pool_type, w_rd_col};

    always_ff @(posedge clk) begin
        if (w_accept && w_store) begin
            r_buf[r_band_row[RW-1:0]][r_col[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_width      <= '0;
            r_k          <= '0;
            r_rows_left  <= '0;
            r_col        <= '0;
            r_band_row   <= '0;
            r_wx         <= '0;
            r_ei         <= '0;
            r_ej         <= '0;
            r_pool_start <= 1'b0;
            r_pool_valid <= 1'b0;
            r_pool_data  <= '0;
            r_frame_done <= 1'b0;
`ifdef POOL_FEED_PAD_EN
            r_pool_type  <= '0;
            r_valid_rows <= '0;
`endif
        end else begin
            r_pool_start <= 1'b0;
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (frame_start) begin
                        r_width     <= w_cfg_width;
                        r_rows_left <= w_cfg_height;
                        r_k         <= (kernel_size == 2'b01) ? c_K3 : c_K2;
                        r_col       <= '0;
                        r_band_row  <= '0;
                        r_wx        <= '0;
                        r_ei        <= '0;
                        r_ej        <= '0;
`ifdef POOL_FEED_PAD_EN
                        r_pool_type <= pool_type;
`endif
                        r_state     <= c_S_FILL;
                    end
                end
                c_S_FILL: begin
                    if (in_valid) begin
                        if (w_row_end) begin
                            r_col       <= '0;
                            r_rows_left <= r_rows_left - 16'd1;
                            if (w_band_done) begin
                                r_band_row <= '0;
                                r_wx       <= '0;
`ifdef POOL_FEED_PAD_EN
                                r_valid_rows <= r_band_row + KW'(1);
`endif
                                if (w_first_fits) begin
                                    r_state <= c_S_START;
                                end else if (w_last_row) begin
                                    r_frame_done <= 1'b1;
                                    r_state      <= c_S_IDLE;
                                end
                            end else begin
                                r_band_row <= r_band_row + KW'(1);
                                if (w_last_row) begin
                                    r_frame_done <= 1'b1;
                                    r_state      <= c_S_IDLE;
                                end
                            end
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                c_S_START: begin
                    if (!pool_busy) begin
                        r_pool_start <= 1'b1;
                        r_ei         <= '0;
                        r_ej         <= '0;
                        r_state      <= c_S_EMIT;
                    end
                end
                c_S_EMIT: begin
                    r_pool_valid <= 1'b1;
                    r_pool_data  <= w_emit_data;
                    if (w_ej_last) begin
                        r_ej <= '0;
                        if (w_ei_last) begin
                            r_ei    <= '0;
                            r_state <= c_S_WAIT;
                        end else begin
                            r_ei <= r_ei + KW'(1);
                        end
                    end else begin
                        r_ej <= r_ej + KW'(1);
                    end
                end
                c_S_WAIT: begin
                    if (pool_done) begin
                        if (w_next_fits) begin
                            r_wx    <= r_wx + CW'(1);
                            r_state <= c_S_START;
                        end else if (r_rows_left != 16'd0) begin
                            r_state <= c_S_FILL;
                        end else begin
                            r_frame_done <= 1'b1;
                            r_state      <= c_S_IDLE;
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == c_S_FILL);
    assign busy       = (r_state != c_S_IDLE);
    assign pool_start = r_pool_start;
    assign pool_valid = r_pool_valid;
    assign pool_data  = r_pool_data;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pool_window_feeder.sv
`default_nettype none
// tb_pool_window_feeder: directed, table-driven check of pool_window_feeder
// with a small pooling-unit responder.
module tb_pool_window_feeder;

    localparam int DW = 8;
    localparam int MW = 64;
    localparam int MK = 3;
    localparam int CW = $clog2(MW) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg_width;
    logic [15:0]   cfg_height;
    logic [1:0]    kernel_size;
    logic [1:0]    pool_type;
    logic          frame_start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          pool_start;
    logic          pool_valid;
    logic [DW-1:0] pool_data;
    logic          pool_busy;
    logic          pool_done;
    logic          busy;
    logic          frame_done;

    logic model_busy;
    logic hold_busy;
    int   cur_kk;

    assign pool_busy = model_busy | hold_busy;

    always #5 clk = ~clk;

    pool_window_feeder #(
        .DATA_WIDTH (DW),
        .MAX_WIDTH  (MW),
        .MAX_KERNEL (MK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .kernel_size (kernel_size),
        .pool_type   (pool_type),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .pool_start  (pool_start),
        .pool_valid  (pool_valid),
        .pool_data   (pool_data),
        .pool_busy   (pool_busy),
        .pool_done   (pool_done),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [1:0]       ks;
        int               w;
        int               h;
        logic [1:0]       pt;
        int               base;
        int               exp_starts;
        int               exp_n;
        logic [8*18-1:0]  exp;
    } vec_t;

    vec_t vt[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] got_q[$];
    int   n_start = 0;
    int   n_fd    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: all DUT outputs are sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (pool_valid) got_q.push_back(pool_data);
            if (pool_start) n_start++;
            if (frame_done) n_fd++;
        end
    end

    // Pooling-unit responder: busy from pool_start until a pool_done pulse.
    initial begin
        model_busy = 1'b0;
        pool_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (pool_start) begin
                int cnt;
                int g;
                cnt = 0;
                g   = 0;
                @(posedge clk);
                #1 model_busy = 1'b1;
                while (cnt < cur_kk && g < 100) begin
                    @(negedge clk);
                    g++;
                    if (pool_valid) cnt++;
                end
                repeat (2) @(posedge clk);
                #1;
                pool_done  = 1'b1;
                model_busy = 1'b0;
                @(posedge clk);
                #1 pool_done = 1'b0;
            end
        end
    end

    task automatic clear_obs();
        got_q.delete();
        n_start = 0;
        n_fd    = 0;
    endtask

    task automatic start_frame(input vec_t v);
        cfg_width   = CW'(v.w);
        cfg_height  = 16'(v.h);
        kernel_size = v.ks;
        pool_type   = v.pt;
        cur_kk      = (v.ks == 2'd1) ? 9 : 4;
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        // Config ports must be ignored once the frame has begun.
        cfg_width   = CW'(13);
        cfg_height  = 16'd1;
        kernel_size = v.ks ^ 2'b01;
        pool_type   = ~v.pt;
    endtask

    task automatic send_samples(input vec_t v, input string tag);
        for (int i = 0; i < v.w * v.h; i++) begin
            int g;
            in_valid = 1'b1;
            in_data  = 8'(v.base + i);
            g = 0;
            @(negedge clk);
            while (!in_ready && g < 500) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready) begin
                chk($sformatf("%s in_ready timeout at sample %0d", tag, i), 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag);
        int g;
        g = 0;
        while (n_fd == 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk({tag, " frame_done seen"}, n_fd, 1);
    endtask

    task automatic check_stream(input vec_t v, input string tag);
        chk({tag, " pool_start count"}, n_start, v.exp_starts);
        chk({tag, " sample count"}, got_q.size(), v.exp_n);
        for (int i = 0; i < v.exp_n; i++) begin
            int act;
            act = (i < got_q.size()) ? int'(got_q[i]) : -1;
            chk($sformatf("%s sample %0d", tag, i), act, int'(v.exp[(v.exp_n-1-i)*8 +: 8]));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_obs();
        start_frame(v);
        send_samples(v, tag);
        wait_frame_done(tag);
        repeat (4) @(negedge clk);
        check_stream(v, tag);
        chk({tag, " single frame_done"}, n_fd, 1);
        chk({tag, " busy after frame"}, int'(busy), 0);
        chk({tag, " in_ready after frame"}, int'(in_ready), 0);
    endtask

    initial begin
        vec_t v;
        int   bad;
        int   g;

        rst         = 1'b1;
        cfg_width   = '0;
        cfg_height  = '0;
        kernel_size = '0;
        pool_type   = '0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        hold_busy   = 1'b0;
        cur_kk      = 4;

        vt.push_back('{2'd0, 4, 2, 2'd0, 1, 2, 8,
            {8'd1, 8'd2, 8'd5, 8'd6, 8'd3, 8'd4, 8'd7, 8'd8}});
`ifdef POOL_FEED_PAD_EN
        vt.push_back('{2'd0, 3, 3, 2'd0, 1, 4, 16,
            {8'd1, 8'd2, 8'd4, 8'd5, 8'd3, 8'h80, 8'd6, 8'h80,
             8'd7, 8'd8, 8'h80, 8'h80, 8'd9, 8'h80, 8'h80, 8'h80}});
        vt.push_back('{2'd1, 4, 2, 2'd1, 0, 2, 18,
            {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd0, 8'd0, 8'd0,
             8'd3, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}});
`else
        vt.push_back('{2'd1, 7, 3, 2'd0, 0, 2, 18,
            {8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9, 8'd14, 8'd15, 8'd16,
             8'd3, 8'd4, 8'd5, 8'd10, 8'd11, 8'd12, 8'd17, 8'd18, 8'd19}});
        vt.push_back('{2'd0, 2, 5, 2'd1, 10, 2, 8,
            {8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17}});
        vt.push_back('{2'd0, 1, 2, 2'd0, 0, 0, 0, '0});
        vt.push_back('{2'd3, 5, 3, 2'd0, 0, 2, 8,
            {8'd0, 8'd1, 8'd5, 8'd6, 8'd2, 8'd3, 8'd7, 8'd8}});
        vt.push_back('{2'd1, 3, 2, 2'd0, 0, 0, 0, '0});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset pool_start", int'(pool_start), 0);
        chk("reset pool_valid", int'(pool_valid), 0);
        chk("reset pool_data", int'(pool_data), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset in_ready", int'(in_ready), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle in_ready", int'(in_ready), 0);

        foreach (vt[i]) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Pooling unit held busy while a window is ready.
        v = vt[0];
        clear_obs();
        hold_busy = 1'b1;
        start_frame(v);
        send_samples(v, "hold");
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (pool_start) bad++;
        end
        chk("hold no pool_start", bad, 0);
        chk("hold busy", int'(busy), 1);
        chk("hold in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 hold_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold release one start", n_start, 1);
        wait_frame_done("hold");
        repeat (4) @(negedge clk);
        check_stream(v, "hold");

        // Reset in the middle of window emission.
        v = '{2'd1, 7, 3, 2'd0, 0, 2, 0, '0};
        clear_obs();
        start_frame(v);
        send_samples(v, "rstemit");
        g = 0;
        while (got_q.size() < 3 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("rstemit emission reached", int'(got_q.size() >= 3), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstemit pool_valid", int'(pool_valid), 0);
        chk("rstemit pool_start", int'(pool_start), 0);
        chk("rstemit in_ready", int'(in_ready), 0);
        chk("rstemit busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_obs();
        repeat (120) @(negedge clk);
        chk("rstemit no start after reset", n_start, 0);
        chk("rstemit no samples after reset", got_q.size(), 0);
        chk("rstemit no frame_done after reset", n_fd, 0);
        run_vec(vt[0], "recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
